// File: rtl/fpu_operand_skid.sv
`default_nettype none
// ============================================================================
// Module      : fpu_operand_skid
// Description : Two-entry skid buffer for FPU operand bundles (A, B, opcode);
//               all outputs are decoded from registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_operand_skid #(
    parameter int DW = 32,
    parameter int OW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [OW-1:0] in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [OW-1:0] out_op,
    output logic [1:0]    count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [DW-1:0] r_head_a;
    logic [DW-1:0] r_head_b;
    logic [OW-1:0] r_head_op;
    logic [DW-1:0] r_skid_a;
    logic [DW-1:0] r_skid_b;
    logic [OW-1:0] r_skid_op;
    logic          w_accept;
    logic          w_drain;
    logic          w_head_from_in;
    logic          w_head_from_skid;
    logic          w_skid_from_in;

    assign in_ready  = (r_state != S_FULL);
    assign out_valid = (r_state != S_EMPTY);
    assign count     = r_state;
    assign out_a     = r_head_a;
    assign out_b     = r_head_b;
    assign out_op    = r_head_op;

    assign w_accept = in_valid & in_ready;
    assign w_drain  = out_valid & out_ready;

    always_comb begin
        w_next_state     = r_state;
        w_head_from_in   = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_head_from_in = 1'b1;
                    w_next_state   = S_ONE;
                end
            end
            S_ONE: begin
                if (w_accept && w_drain) begin
                    w_head_from_in = 1'b1;
                end else if (w_accept) begin
                    w_skid_from_in = 1'b1;
                    w_next_state   = S_FULL;
                end else if (w_drain) begin
                    // head keeps its stale contents while empty
                    w_next_state = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_drain) begin
                    w_head_from_skid = 1'b1;
                    w_next_state     = S_ONE;
                end
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_a  <= '0;
            r_head_b  <= '0;
            r_head_op <= '0;
            r_skid_a  <= '0;
            r_skid_b  <= '0;
            r_skid_op <= '0;
        end else begin
            if (w_head_from_in) begin
                r_head_a  <= in_a;
                r_head_b  <= in_b;
                r_head_op <= in_op;
            end else if (w_head_from_skid) begin
                r_head_a  <= r_skid_a;
                r_head_b  <= r_skid_b;
                r_head_op <= r_skid_op;
            end
            if (w_skid_from_in) begin
                r_skid_a  <= in_a;
                r_skid_b  <= in_b;
                r_skid_op <= in_op;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_operand_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_operand_skid
// Description : Directed and randomized bench for fpu_operand_skid against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_operand_skid;

    localparam int DW = 32;
    localparam int OW = 3;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] op;
    } bundle_t;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [OW-1:0] in_op;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [OW-1:0] out_op;
    logic [1:0]    count;

    fpu_operand_skid #(.DW(DW), .OW(OW)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      n_checks;
    int      n_fail;
    bundle_t q_model[$];
    bundle_t last_head;
    int      next_push;
    int      next_deliver;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO of at most two bundles; head shows the oldest, or the last shown when empty.
    task automatic model_edge(output logic accepted);
        logic acc;
        logic drn;
        bundle_t nb;
        acc = 1'b0;
        if (reset) begin
            q_model.delete();
            last_head = '0;
        end else begin
            acc = in_valid && (q_model.size() < 2);
            drn = out_ready && (q_model.size() > 0);
            nb.a = in_a; nb.b = in_b; nb.op = in_op;
            if (drn) void'(q_model.pop_front());
            if (acc) q_model.push_back(nb);
            if (q_model.size() > 0) last_head = q_model[0];
        end
        accepted = acc;
    endtask

    task automatic compare_all();
        check_val("count",     64'(count),     64'(q_model.size()));
        check_val("in_ready",  64'(in_ready),  64'(q_model.size() < 2));
        check_val("out_valid", 64'(out_valid), 64'(q_model.size() > 0));
        check_val("out_a",     64'(out_a),     64'(last_head.a));
        check_val("out_b",     64'(out_b),     64'(last_head.b));
        check_val("out_op",    64'(out_op),    64'(last_head.op));
    endtask

    task automatic cycle(input logic rst, input logic iv, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [OW-1:0] op, input logic ordy);
        logic acc;
        reset = rst; in_valid = iv; in_a = a; in_b = b; in_op = op; out_ready = ordy;
        @(posedge clk);
        model_edge(acc);
        #1;
        compare_all();
    endtask

    initial begin
        logic          acc;
        logic          rv;
        logic          iv;
        logic          ordy;
        logic [DW-1:0] rb;
        logic [OW-1:0] rop;
        n_checks = 0; n_fail = 0;
        q_model = {}; last_head = '0;
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;

        // Reset for two cycles, with junk on the inputs
        cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 3'd5, 1'b1);
        cycle(1'b1, 1'b0, '0, '0, '0, 1'b0);
        check_val("rst_in_ready",  64'(in_ready),  64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_a",     64'(out_a),     64'd0);

        // Single transfer
        cycle(1'b0, 1'b1, 32'h3F80_0000, 32'h4000_0000, 3'd3, 1'b1);
        check_val("single_valid", 64'(out_valid), 64'd1);
        check_val("single_a",     64'(out_a),     64'h3F80_0000);
        check_val("single_b",     64'(out_b),     64'h4000_0000);
        check_val("single_op",    64'(out_op),    64'd3);
        check_val("single_count", 64'(count),     64'd1);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
        check_val("single_drained", 64'(out_valid), 64'd0);

        // Fill on stall, third push refused
        cycle(1'b0, 1'b1, 32'h1, 32'h11, 3'd1, 1'b0);
        cycle(1'b0, 1'b1, 32'h2, 32'h22, 3'd2, 1'b0);
        cycle(1'b0, 1'b1, 32'h3, 32'h33, 3'd3, 1'b0);
        check_val("fill_count",    64'(count),    64'd2);
        check_val("fill_in_ready", 64'(in_ready), 64'd0);
        check_val("fill_out_a",    64'(out_a),    64'h1);

        // Drain from full
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
        check_val("drain1_a",     64'(out_a),    64'h2);
        check_val("drain1_ready", 64'(in_ready), 64'd1);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
        check_val("drain2_valid", 64'(out_valid), 64'd0);
        check_val("drain2_count", 64'(count),     64'd0);
        check_val("drain2_ready", 64'(in_ready),  64'd1);

        // Streaming at one bundle per cycle
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, DW'(i), DW'(i + 100), OW'(i), 1'b1);
            check_val("stream_a",     64'(out_a), 64'(i));
            check_val("stream_count", 64'(count), 64'd1);
        end
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);

        // Reset while full discards both held bundles
        cycle(1'b0, 1'b1, 32'hA1, 32'hB1, 3'd6, 1'b0);
        cycle(1'b0, 1'b1, 32'hA2, 32'hB2, 3'd7, 1'b0);
        check_val("pre_rst_count", 64'(count), 64'd2);
        cycle(1'b1, 1'b1, 32'hA3, 32'hB3, 3'd1, 1'b1);
        check_val("midrst_valid", 64'(out_valid), 64'd0);
        check_val("midrst_count", 64'(count),     64'd0);
        check_val("midrst_a",     64'(out_a),     64'd0);
        cycle(1'b0, 1'b1, 32'h55, 32'h66, 3'd2, 1'b0);
        check_val("postrst_first_a", 64'(out_a), 64'h55);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);

        // Random backpressure with sequence-numbered operand A
        next_push = 0; next_deliver = 0;
        for (int c = 0; c < 10000; c++) begin
            rv   = ($urandom_range(0, 199) == 0);
            iv   = $urandom_range(0, 1) == 1;
            ordy = $urandom_range(0, 2) != 0;
            if (c % 1000 < 300) ordy = $urandom_range(0, 3) == 0;
            rb   = $urandom;
            rop  = OW'($urandom);
            if (!rv && out_valid && ordy) begin
                check_val("order_a", 64'(out_a), 64'(next_deliver));
                next_deliver++;
            end
            reset = rv; in_valid = iv; in_a = DW'(next_push); in_b = rb; in_op = rop; out_ready = ordy;
            @(posedge clk);
            model_edge(acc);
            if (rv) next_deliver = next_push;
            else if (acc) next_push++;
            #1;
            compare_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
